mag_window_detector: RTL and testbench
======================================

# mag_window_detector

Windowed magnitude detector placed directly downstream of the `abs` operator. It accepts a stream of 2's-complement samples with a valid/ready handshake and converts each sample to a saturated unsigned magnitude. Over each window of 2^WIN_LOG2 accepted samples it computes the peak magnitude, the magnitude sum and the mean magnitude. Results go out on a valid/ready output port that holds until accepted. It feeds the envelope/level-control logic of the interpolator datapath.

## Interface
- `DATA_WIDTH`, 14: input sample width, 2's complement.
- `WIN_LOG2`, 4: log2 of window length; legal range 1..8.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `clear_i`  in  1: synchronous restart of the current window.
- `data_i`  in  DATA_WIDTH: input sample.
- `valid_i`  in  1: `data_i` is valid.
- `ready_o`  out  1: block can accept a sample.
- `peak_o`  out  DATA_WIDTH-1: maximum magnitude in the window.
- `sum_o`  out  DATA_WIDTH-1+WIN_LOG2: sum of the window's magnitudes.
- `mean_o`  out  DATA_WIDTH-1: `sum_o >> WIN_LOG2`, truncated.
- `valid_o`  out  1: result valid.
- `ready_i`  in  1: downstream accepts the result.

## Operation
- A sample is accepted when `valid_i && ready_o`.
- Magnitude: |data_i|, DATA_WIDTH-1 bits unsigned.
  - Exception: data_i = 100…0 (most negative) gives all-ones (2^(DATA_WIDTH-1)-1). It is saturated, not wrapped to 0.
- Internal registers: `cnt` (WIN_LOG2 bits), `acc_sum` (DATA_WIDTH-1+WIN_LOG2 bits, cannot overflow), `acc_peak`.
- First sample of a window (cnt = 0): `acc_sum` and `acc_peak` load the magnitude. Otherwise the magnitude is added to `acc_sum` and `acc_peak` becomes max(acc_peak, mag).
- Last sample of a window (cnt = 2^WIN_LOG2-1): the final sum and peak, including this sample, are written to the output registers. `valid_o` sets and `cnt` wraps to 0.
- States:
  - ACC: accumulating.
  - FULL: a result is pending (`valid_o`=1) and the next window is running.
  - STALL: a result is pending and the next window has reached its last sample.
- Transitions:
  - ACC→FULL on window completion.
  - FULL→ACC on `ready_i` with no completion in the same cycle.
  - FULL→FULL on `ready_i` with a completion in the same cycle; the new result replaces the old one with no gap.
  - FULL→STALL when cnt = 2^WIN_LOG2-1 and `valid_o && !ready_i`.
  - STALL→FULL on `ready_i`.
- `ready_o` = 0 only in STALL. It is registered and does not depend combinationally on `ready_i`.
- `clear_i`: `cnt`, `acc_sum` and `acc_peak` go to 0. A sample offered in the same cycle is dropped, and `ready_o` is still 1 in that cycle. A pending result and `valid_o` are unaffected. STALL returns to FULL.
- Output registers stay stable while `valid_o && !ready_i`.

## Timing
- Reset values: `valid_o`=0, `ready_o`=1, `peak_o`=0, `sum_o`=0, `mean_o`=0; state ACC, `cnt`=0.
- Latency: last sample accepted at edge k → `valid_o`=1 with its result after edge k (cycle k+1).
- Throughput: one sample per cycle while `ready_i` is held 1. There is no bubble at window boundaries.
- Reset asserted mid-window or with a result pending: all state is lost immediately and the pending result is discarded.
- `mean_o` is `sum_o[DATA_WIDTH-2+WIN_LOG2 : WIN_LOG2]`, taken from the same register as `sum_o`.

## Structure
- Shared package/include file holds:
  - The `SUM_WIDTH = DATA_WIDTH-1+WIN_LOG2` derivation.
  - The state encodings ACC=2'd0, FULL=2'd1, STALL=2'd2.
  - The saturation constant definition.
- One sub-module: `abs` (DATA_WIDTH) produces the raw magnitude. A parallel comparator detects the most negative input and forces saturation.
- One FSM, an accumulator datapath, and an output register bank.

## Test plan
- DATA_WIDTH=14, WIN_LOG2=2, `ready_i`=1; samples 5, -7, 3, -2 → one cycle after the 4th: `valid_o`=1, `peak_o`=7, `sum_o`=17, `mean_o`=4.
- Window -8192, 0, 0, 0 → `peak_o`=8191, `sum_o`=8191, `mean_o`=2047. Window of four -8192 → `sum_o`=32764, `mean_o`=8191.
- Continuous input, `ready_i`=0 → after 8 samples `ready_o`=0 with the first result held. Raise `ready_i` → next cycle `valid_o`=1 with the second result and `ready_o`=1; no sample is lost.
- Samples 100, 100, then `clear_i` alongside sample 50, then 1, 2, 3, 4 → result `peak_o`=4, `sum_o`=10; 50 is discarded.
- Assert `rst_i` asynchronously mid-window and while `valid_o`=1 → outputs take their reset values immediately; the next full window produces a correct, uncontaminated result.
- Random stimulus with random `valid_i`/`ready_i` against a reference model → every window's peak, sum and mean match; there are no duplicates or drops.

Source files
------------

// File: rtl/mag_window_detector_pkg.sv
// Shared types and width/constant helpers for the windowed magnitude detector.
// Width helpers are functions so that each instance derives them from its own parameters.
package mag_window_detector_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic int sum_width(input int data_width, input int win_log2);
        return data_width - 1 + win_log2;
    endfunction

    // Largest representable magnitude; the most negative input is clamped to this.
    function automatic int sat_mag(input int data_width);
        return (1 << (data_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/mag_window_detector_abs.sv
// Raw two's-complement magnitude, truncated to DATA_WIDTH-1 bits.
// The most negative input wraps to zero here; the parent clamps that case.
module mag_window_detector_abs #(
    parameter int DATA_WIDTH = 14
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-2:0] mag
);

    // Low bits of a negation depend only on the low bits of the operand.
    assign mag = data[DATA_WIDTH-1] ? ((~data[DATA_WIDTH-2:0]) + (DATA_WIDTH-1)'(1))
                                    : data[DATA_WIDTH-2:0];

endmodule

// File: rtl/mag_window_detector.sv
// Windowed magnitude detector: per window of 2^WIN_LOG2 accepted samples it reports
// peak, sum and mean magnitude on a valid/ready port that holds until accepted.
module mag_window_detector
    import mag_window_detector_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int WIN_LOG2   = 4,
    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, WIN_LOG2)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-2:0] peak_o,
    output logic [SUM_WIDTH-1:0]  sum_o,
    output logic [DATA_WIDTH-2:0] mean_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int MAG_WIDTH = DATA_WIDTH - 1;
    localparam logic [MAG_WIDTH-1:0]  SAT_MAG  = MAG_WIDTH'(sat_mag(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [WIN_LOG2-1:0]   LAST_CNT = '1;

    state_t                state;
    state_t                state_next;
    logic [MAG_WIDTH-1:0]  raw_mag;
    logic [MAG_WIDTH-1:0]  mag;
    logic [WIN_LOG2-1:0]   cnt;
    logic [SUM_WIDTH-1:0]  acc_sum;
    logic [SUM_WIDTH-1:0]  sum_next;
    logic [MAG_WIDTH-1:0]  acc_peak;
    logic [MAG_WIDTH-1:0]  peak_next;
    logic                  accept;
    logic                  last;
    logic                  load_out;
    logic                  load_stalled;

    mag_window_detector_abs #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_abs (
        .data(data_i),
        .mag (raw_mag)
    );

    assign mag = (data_i == MOST_NEG) ? SAT_MAG : raw_mag;

    assign ready_o = (state != STALL);
    assign valid_o = (state != ACC);
    assign accept  = valid_i && ready_o && !clear_i;
    assign last    = accept && (cnt == LAST_CNT);

    // The first sample of a window reloads rather than accumulates.
    assign sum_next  = (cnt == '0) ? SUM_WIDTH'(mag) : acc_sum + SUM_WIDTH'(mag);
    assign peak_next = ((cnt == '0) || (mag > acc_peak)) ? mag : acc_peak;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // STALL parks a finished window in the accumulators until the output port frees up.
    always_comb begin
        state_next   = state;
        load_out     = 1'b0;
        load_stalled = 1'b0;
        unique case (state)
            ACC: begin
                if (last) begin
                    state_next = FULL;
                    load_out   = 1'b1;
                end
            end
            FULL: begin
                if (ready_i) begin
                    if (last) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = ACC;
                    end
                end else if (last) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (clear_i) begin
                    state_next = ready_i ? ACC : FULL;
                end else if (ready_i) begin
                    state_next   = FULL;
                    load_stalled = 1'b1;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            acc_sum  <= '0;
            acc_peak <= '0;
        end else if (clear_i) begin
            cnt      <= '0;
            acc_sum  <= '0;
            acc_peak <= '0;
        end else if (accept) begin
            cnt      <= cnt + WIN_LOG2'(1);
            acc_sum  <= sum_next;
            acc_peak <= peak_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_o <= '0;
            sum_o  <= '0;
        end else if (load_out) begin
            peak_o <= peak_next;
            sum_o  <= sum_next;
        end else if (load_stalled) begin
            peak_o <= acc_peak;
            sum_o  <= acc_sum;
        end
    end

    assign mean_o = sum_o[SUM_WIDTH-1:WIN_LOG2];

endmodule

// File: tb/tb_mag_window_detector.sv
// Self-checking bench for mag_window_detector: directed scenarios plus a randomized
// run against a queue-based reference model of completed windows.
module tb_mag_window_detector;

    localparam int DW = 14;
    localparam int WL = 2;
    localparam int N  = 1 << WL;
    localparam int MW = DW - 1;
    localparam int SW = DW - 1 + WL;
    localparam int RW = 1 + MW + SW + MW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [DW-1:0] data;
    logic          sample_valid;
    logic          sample_ready;
    logic [MW-1:0] peak;
    logic [SW-1:0] sum;
    logic [MW-1:0] mean;
    logic          result_valid;
    logic          result_ready;

    int checks   = 0;
    int failures = 0;

    mag_window_detector #(
        .DATA_WIDTH(DW),
        .WIN_LOG2  (WL)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .clear_i(clear),
        .data_i (data),
        .valid_i(sample_valid),
        .ready_o(sample_ready),
        .peak_o (peak),
        .sum_o  (sum),
        .mean_o (mean),
        .valid_o(result_valid),
        .ready_i(result_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [RW-1:0] res(input logic v, input int p, input int s, input int m);
        return {v, MW'(p), SW'(s), MW'(m)};
    endfunction

    // Inputs change at the falling edge; one call spans exactly one rising edge.
    task automatic cycle(input logic v, input int d, input logic r, input logic c);
        sample_valid = v;
        data         = DW'(d);
        result_ready = r;
        clear        = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        data         = '0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b1, res(0, 0, 0, 0)})
            $display("[TB] FAIL reset_values got=%h want=%h",
                     {sample_ready, result_valid, peak, sum, mean}, {1'b1, res(0, 0, 0, 0)});
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b1, res(0, 0, 0, 0)}) failures++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        cycle(1, 5, 1, 0);
        cycle(1, -7, 1, 0);
        cycle(1, 3, 1, 0);
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early_valid got=%0b want=0", result_valid);
        end
        cycle(1, -2, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 7, 17, 4)) begin
            failures++;
            $display("[TB] FAIL basic_result got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 7, 17, 4));
        end
        cycle(0, 0, 1, 0);
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_drain got=%0b want=0", result_valid);
        end
    endtask

    task automatic test_saturation();
        cycle(1, -8192, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 8191, 8191, 2047)) begin
            failures++;
            $display("[TB] FAIL sat_single got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 8191, 8191, 2047));
        end
        for (int i = 0; i < 4; i++) cycle(1, -8192, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 8191, 32764, 8191)) begin
            failures++;
            $display("[TB] FAIL sat_full got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 8191, 32764, 8191));
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            cycle(1, i, 0, 0);
            if (i == 4) begin
                checks++;
                if ({result_valid, peak, sum, mean} !== res(1, 4, 10, 2)) begin
                    failures++;
                    $display("[TB] FAIL b2b_first got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 4, 10, 2));
                end
            end
        end
        checks++;
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b0, res(1, 4, 10, 2)}) begin
            failures++;
            $display("[TB] FAIL b2b_stall got=%h want=%h",
                     {sample_ready, result_valid, peak, sum, mean}, {1'b0, res(1, 4, 10, 2)});
        end
        cycle(1, 9, 0, 0);
        checks++;
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b0, res(1, 4, 10, 2)}) begin
            failures++;
            $display("[TB] FAIL b2b_hold got=%h want=%h",
                     {sample_ready, result_valid, peak, sum, mean}, {1'b0, res(1, 4, 10, 2)});
        end
        cycle(1, 9, 1, 0);
        checks++;
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b1, res(1, 8, 26, 6)}) begin
            failures++;
            $display("[TB] FAIL b2b_second got=%h want=%h",
                     {sample_ready, result_valid, peak, sum, mean}, {1'b1, res(1, 8, 26, 6)});
        end
        for (int i = 9; i <= 12; i++) cycle(1, i, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 12, 42, 10)) begin
            failures++;
            $display("[TB] FAIL b2b_third got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 12, 42, 10));
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_clear();
        cycle(1, 100, 1, 0);
        cycle(1, 100, 1, 0);
        sample_valid = 1'b1;
        data         = DW'(50);
        result_ready = 1'b1;
        clear        = 1'b1;
        #1;
        checks++;
        if (sample_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clear_ready got=%0b want=1", sample_ready);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) cycle(1, i, 1, 0);
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_early_valid got=%0b want=0", result_valid);
        end
        cycle(1, 4, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 4, 10, 2)) begin
            failures++;
            $display("[TB] FAIL clear_result got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 4, 10, 2));
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(1, 20, 0, 0);
        cycle(1, 30, 0, 0);
        cycle(1, 30, 0, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 20, 80, 20)) begin
            failures++;
            $display("[TB] FAIL arst_pending got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 20, 80, 20));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sample_ready, result_valid, peak, sum, mean} !== {1'b1, res(0, 0, 0, 0)}) begin
            failures++;
            $display("[TB] FAIL arst_immediate got=%h want=%h",
                     {sample_ready, result_valid, peak, sum, mean}, {1'b1, res(0, 0, 0, 0)});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) cycle(1, i, 1, 0);
        checks++;
        if ({result_valid, peak, sum, mean} !== res(1, 4, 10, 2)) begin
            failures++;
            $display("[TB] FAIL arst_after got=%h want=%h", {result_valid, peak, sum, mean}, res(1, 4, 10, 2));
        end
        cycle(0, 0, 1, 0);
    endtask

    // Model: queue of finished windows; its depth alone determines valid and ready.
    task automatic test_random(input int n_cycles);
        int   q_peak[$];
        int   q_sum[$];
        int   win_cnt;
        int   win_sum;
        int   win_peak;
        int   pending;
        int   d;
        int   m;
        int   windows;
        logic v;
        logic r;
        logic c;
        win_cnt  = 0;
        win_sum  = 0;
        win_peak = 0;
        windows  = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < n_cycles + 20; t++) begin
            v = (t < n_cycles) && ($urandom_range(0, 9) < 7);
            r = (t >= n_cycles) || ($urandom_range(0, 1) == 1);
            c = (t < n_cycles) && ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 7))
                0:       d = -8192;
                1:       d = 8191;
                default: d = int'($urandom_range(0, 16383)) - 8192;
            endcase
            sample_valid = v;
            data         = DW'(d);
            result_ready = r;
            clear        = c;
            #1;
            pending = q_sum.size();
            checks++;
            if (result_valid !== (pending != 0)) begin
                failures++;
                $display("[TB] FAIL rand_valid t=%0d got=%0b want=%0b", t, result_valid, pending != 0);
            end
            checks++;
            if (sample_ready !== (pending < 2)) begin
                failures++;
                $display("[TB] FAIL rand_ready t=%0d got=%0b want=%0b", t, sample_ready, pending < 2);
            end
            if (pending != 0 && result_valid === 1'b1) begin
                checks++;
                if ({peak, sum, mean} !== {MW'(q_peak[0]), SW'(q_sum[0]), MW'(q_sum[0] >> WL)}) begin
                    failures++;
                    $display("[TB] FAIL rand_result t=%0d got p=%0d s=%0d m=%0d want p=%0d s=%0d m=%0d",
                             t, peak, sum, mean, q_peak[0], q_sum[0], q_sum[0] >> WL);
                end
            end
            if (pending != 0 && r) begin
                void'(q_peak.pop_front());
                void'(q_sum.pop_front());
            end
            if (c) begin
                win_cnt = 0;
                if (pending == 2) begin
                    void'(q_peak.pop_back());
                    void'(q_sum.pop_back());
                end
            end else if (v && pending < 2) begin
                m = (d < 0) ? -d : d;
                if (m > 8191) m = 8191;
                win_sum  = (win_cnt == 0) ? m : win_sum + m;
                win_peak = (win_cnt == 0 || m > win_peak) ? m : win_peak;
                win_cnt++;
                if (win_cnt == N) begin
                    q_peak.push_back(win_peak);
                    q_sum.push_back(win_sum);
                    win_cnt = 0;
                    windows++;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (q_sum.size() != 0 || result_valid !== 1'b0 || windows < 50) begin
            failures++;
            $display("[TB] FAIL rand_drain left=%0d valid=%0b windows=%0d want left=0 valid=0 windows>=50",
                     q_sum.size(), result_valid, windows);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
